seq_timing_gen: RTL and testbench
=================================

# seq_timing_gen

Parametrised sequence counter with integrated one-hot timing decoder; it generates the control-unit timing signals T0..T(N-1) for the CPU's instruction cycle. It generalises the fixed 3-bit counter and 3-to-8 decoder pair. It adds a configurable state count, clear and load, wrap or saturate mode, and terminal and error flags. It sits between the control unit's clr/inc/load requests and the control-word decode logic.

## Interface

Parameters:
- N_STATES, 8, number of timing states (2..256); one-hot output width.
- CW, 3, count register width; must satisfy 2^CW >= N_STATES (static check: elaboration error otherwise).
- WRAP, 1, 1 = wrap N_STATES-1 -> 0 on inc; 0 = saturate at N_STATES-1.

Ports:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-high; forces count to 0.
- inc  in  1  advance count by one this cycle.
- clr  in  1  synchronous return to T0 (end-of-instruction clear).
- ld  in  1  load ld_val into count.
- ld_val  in  CW  value loaded when ld=1.
- count  out  CW  current state index (registered).
- t  out  N_STATES  one-hot decode of count: t[count]=1, all other bits 0.
- last  out  1  1 when count == N_STATES-1 (combinational from count).
- wrap_p  out  1  registered one-cycle pulse: the previous edge wrapped N_STATES-1 -> 0 (WRAP=1 only).
- ld_err  out  1  registered one-cycle pulse: the previous edge saw ld with ld_val >= N_STATES.

## Operation

- Priority at each rising edge, highest first: reset > clr > ld > inc > hold.
- reset=1: count=0, wrap_p=0, ld_err=0.
- clr=1: count=0; wrap_p=0; ld_err=0. A concurrent ld or inc is ignored.
- ld=1 with ld_val < N_STATES: count=ld_val. A concurrent inc is ignored.
- ld=1 with ld_val >= N_STATES: count holds, ld_err=1 for one cycle, and inc is ignored that cycle.
- inc=1 with count < N_STATES-1: count=count+1.
- inc=1 with count == N_STATES-1:
  - WRAP=1: count=0 and wrap_p=1 for one cycle.
  - WRAP=0: count holds at N_STATES-1 and wrap_p stays 0.
- Otherwise count holds. wrap_p and ld_err are 0 on every edge that does not set them.
- Increment arithmetic is CW bits wide; count never takes a value >= N_STATES by any path.
- t is exactly one-hot at all times, including immediately after reset (t=1, i.e. bit 0 set).
- When N_STATES is not a power of two, decode bits for unreachable codes do not exist; t has width N_STATES only.

## Timing

- Reset values: count=0, t=...0001, last=(N_STATES==1 ? 1 : 0) (always 0 for legal N_STATES >= 2), wrap_p=0, ld_err=0.
- Latency: a request sampled at edge k is visible on count, t and last after edge k (same-cycle combinational decode of the registered count); there is no extra decode stage.
- wrap_p and ld_err are asserted in the cycle following the causing edge, for exactly one cycle.
- Continuous inc with WRAP=1 cycles through T0..T(N-1) with period N_STATES clocks; wrap_p pulses once per period, coincident with t[0].
- Reset mid-sequence takes effect at the next edge regardless of inc/clr/ld; there is no partial state.
- No combinational path from any input to any output.

## Test plan

- Reset and free-run, N_STATES=8, WRAP=1: hold reset for 3 cycles, then inc=1 for 20 cycles. Required: t=0x01 during reset; then t steps 0x02, 0x04 .. 0x80, 0x01; wrap_p pulses at cycles 8 and 16 after release; last=1 whenever t=0x80.
- Saturate, WRAP=0, N_STATES=5: inc held for 10 cycles. Required: count 1, 2, 3, 4, 4, 4 ...; last stays 1 from count=4 onward; wrap_p never asserts.
- Priority: at count=3, apply clr=ld=inc=1 with ld_val=6. Required: count=0. Next cycle apply ld=inc=1 with ld_val=6. Required: count=6, not 7.
- Illegal load, N_STATES=6, CW=3: at count=2, apply ld=1 with ld_val=7 and inc=1. Required: count stays 2, ld_err=1 for exactly one cycle, t=0x04.
- Reset mid-operation: free-run to count=5, then reset=1 together with inc=1 for one cycle. Required: count=0, wrap_p=0, ld_err=0. After reset releases, counting resumes 1, 2, ...
- Non-power-of-two wrap, N_STATES=3, CW=2: continuous inc. Required: count follows 0, 1, 2, 0, 1, 2 and never reaches 3; t cycles through 0b001, 0b010, 0b100.

Source files
------------

// File: rtl/seq_timing_gen.sv
// Instruction-cycle sequence counter with one-hot timing decode T0..T(N-1).
// Supports clear, load, wrap/saturate, plus wrap and illegal-load pulses.
module seq_timing_gen #(
    parameter int N_STATES = 8,
    parameter int CW       = 3,
    parameter bit WRAP     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic                ld,
    input  logic [CW-1:0]       ld_val,
    output logic [CW-1:0]       count,
    output logic [N_STATES-1:0] t,
    output logic                last,
    output logic                wrap_p,
    output logic                ld_err
);

    localparam logic [CW-1:0] LAST = CW'(N_STATES - 1);

    if (N_STATES < 2 || N_STATES > 256 || (2 ** CW) < N_STATES) begin : g_bad_cfg
        $error("seq_timing_gen: N_STATES must be 2..256 and fit in CW bits");
    end

    logic [CW-1:0] r_count;
    logic          r_wrap_p;
    logic          r_ld_err;
    logic [CW-1:0] w_count_nxt;
    logic          w_wrap_nxt;
    logic          w_err_nxt;
    logic          w_ld_ok;
    logic          w_at_last;

    assign w_ld_ok   = (32'(ld_val) < 32'(N_STATES));
    assign w_at_last = (r_count == LAST);

    // clr > ld > inc > hold; an illegal load still swallows inc
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (clr) begin
            w_count_nxt = '0;
        end else if (ld) begin
            if (w_ld_ok) begin
                w_count_nxt = ld_val;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (inc) begin
            if (!w_at_last) begin
                w_count_nxt = r_count + 1'b1;
            end else if (WRAP) begin
                w_count_nxt = '0;
                w_wrap_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_wrap_p <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_wrap_p <= w_wrap_nxt;
            r_ld_err <= w_err_nxt;
        end
    end

    always_comb begin
        t = '0;
        for (int i = 0; i < N_STATES; i++) begin
            t[i] = (32'(r_count) == i);
        end
    end

    assign count  = r_count;
    assign last   = w_at_last;
    assign wrap_p = r_wrap_p;
    assign ld_err = r_ld_err;

endmodule

// File: tb/tb_seq_timing_gen.sv
// Bench for seq_timing_gen: four configurations driven in parallel and
// checked against a per-edge behavioural model, vector table and sequences.
module tb_seq_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       inc;
    logic       clr;
    logic       ld;
    logic [2:0] ld_val;

    logic [2:0] c0, c1, c2;
    logic [1:0] c3;
    logic [7:0] t0;
    logic [4:0] t1;
    logic [5:0] t2;
    logic [2:0] t3;
    logic       lst[4];
    logic       wp[4];
    logic       le[4];

    seq_timing_gen #(.N_STATES(8), .CW(3), .WRAP(1'b1)) u0 (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr), .ld(ld),
        .ld_val(ld_val), .count(c0), .t(t0), .last(lst[0]),
        .wrap_p(wp[0]), .ld_err(le[0]));
    seq_timing_gen #(.N_STATES(5), .CW(3), .WRAP(1'b0)) u1 (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr), .ld(ld),
        .ld_val(ld_val), .count(c1), .t(t1), .last(lst[1]),
        .wrap_p(wp[1]), .ld_err(le[1]));
    seq_timing_gen #(.N_STATES(6), .CW(3), .WRAP(1'b1)) u2 (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr), .ld(ld),
        .ld_val(ld_val), .count(c2), .t(t2), .last(lst[2]),
        .wrap_p(wp[2]), .ld_err(le[2]));
    seq_timing_gen #(.N_STATES(3), .CW(2), .WRAP(1'b1)) u3 (
        .clk(clk), .reset(reset), .inc(inc), .clr(clr), .ld(ld),
        .ld_val(ld_val[1:0]), .count(c3), .t(t3), .last(lst[3]),
        .wrap_p(wp[3]), .ld_err(le[3]));

    int         cnt_a[4];
    logic [7:0] t_a[4];
    always_comb begin
        cnt_a[0] = int'(c0);
        cnt_a[1] = int'(c1);
        cnt_a[2] = int'(c2);
        cnt_a[3] = int'(c3);
        t_a[0]   = t0;
        t_a[1]   = 8'(t1);
        t_a[2]   = 8'(t2);
        t_a[3]   = 8'(t3);
    end

    localparam int NS[4] = '{8, 5, 6, 3};
    localparam int WR[4] = '{1, 0, 1, 1};
    localparam int LM[4] = '{8, 8, 8, 4};

    int m_cnt[4];
    int m_wp[4];
    int m_le[4];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[u%0d]: got %0d expected %0d at %0t",
                     nm, k, act, exp, $time);
        end
    endtask

    // Reference: apply the priority rules to an abstract integer state
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int v;
            v = int'(ld_val) % LM[k];
            m_wp[k] = 0;
            m_le[k] = 0;
            if (reset || clr) begin
                m_cnt[k] = 0;
            end else if (ld) begin
                if (v < NS[k]) m_cnt[k] = v;
                else m_le[k] = 1;
            end else if (inc) begin
                if (m_cnt[k] < NS[k] - 1) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end else if (WR[k] == 1) begin
                    m_cnt[k] = 0;
                    m_wp[k]  = 1;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            chk("count", k, cnt_a[k], m_cnt[k]);
            chk("t", k, int'(t_a[k]), 1 << m_cnt[k]);
            chk("last", k, int'(lst[k]), int'(m_cnt[k] == NS[k] - 1));
            chk("wrap_p", k, int'(wp[k]), m_wp[k]);
            chk("ld_err", k, int'(le[k]), m_le[k]);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit l,
                         input bit i, input int v);
        reset  = r;
        clr    = c;
        ld     = l;
        inc    = i;
        ld_val = 3'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit r, c, l, i;
        int v;
        int e0, w0, e2, le2;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 1, 0, 1, 0, 1, 0},
            '{0, 0, 0, 1, 0, 2, 0, 2, 0},
            '{0, 0, 0, 1, 0, 3, 0, 3, 0},
            '{0, 1, 1, 1, 6, 0, 0, 0, 0},
            '{0, 0, 1, 1, 6, 6, 0, 0, 1},
            '{0, 0, 0, 0, 0, 6, 0, 0, 0},
            '{0, 0, 1, 0, 2, 2, 0, 2, 0},
            '{0, 0, 1, 1, 7, 7, 0, 2, 1},
            '{0, 0, 0, 0, 0, 7, 0, 2, 0},
            '{0, 0, 0, 1, 0, 0, 1, 3, 0},
            '{0, 0, 0, 1, 0, 1, 0, 4, 0},
            '{0, 0, 0, 1, 0, 2, 0, 5, 0},
            '{1, 0, 0, 1, 0, 0, 0, 0, 0},
            '{0, 0, 0, 1, 0, 1, 0, 1, 0},
            '{0, 0, 0, 1, 0, 2, 0, 2, 0}
        };
        drive(1, 0, 0, 0, 0);

        // reset held 3 cycles, then 20 cycles of free-run on the 8-state unit
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rst_t", 0, int'(t0), 1);
            chk("rst_wrap", 0, int'(wp[0]), 0);
        end
        drive(0, 0, 0, 1, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk("run_t", 0, int'(t0), 1 << (n % 8));
            chk("run_wrap", 0, int'(wp[0]), int'(n % 8 == 0));
            chk("run_last", 0, int'(lst[0]), int'(n % 8 == 7));
        end

        // saturate (N=5) and non-power-of-two wrap (N=3) from reset
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk("sat_cnt", 1, int'(c1), (n < 4) ? n : 4);
            chk("sat_last", 1, int'(lst[1]), int'(n >= 4));
            chk("sat_wrap", 1, int'(wp[1]), 0);
            chk("n3_cnt", 3, int'(c3), n % 3);
            chk("n3_t", 3, int'(t3), 1 << (n % 3));
        end

        // priority, illegal load and mid-run reset vectors
        for (int n = 0; n < 16; n++) begin
            drive(vt[n].r, vt[n].c, vt[n].l, vt[n].i, vt[n].v);
            tick();
            chk("vec_cnt0", 0, int'(c0), vt[n].e0);
            chk("vec_wrap0", 0, int'(wp[0]), vt[n].w0);
            chk("vec_cnt2", 2, int'(c2), vt[n].e2);
            chk("vec_t2", 2, int'(t2), 1 << vt[n].e2);
            chk("vec_lderr2", 2, int'(le[2]), vt[n].le2);
        end

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(31) == 0, $urandom_range(7) == 0,
                  $urandom_range(3) == 0, $urandom_range(3) != 0,
                  int'($urandom_range(7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
